// File: rtl/nios_mul_pkg.sv
// Shared types and constants for the Nios II multiply issue/collect sequencer.
package nios_mul_pkg;

    localparam int unsigned MUL_W  = 32;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_LO = 3'd1,
        ISSUE_HI = 3'd2,
        DRAIN    = 3'd3,
        RESP     = 3'd4
    } state_t;

    // Tags which pass's result the cell will present a fixed latency later.
    typedef enum logic [1:0] {
        PASS_NONE = 2'd0,
        PASS_LO   = 2'd1,
        PASS_HI   = 2'd2
    } pass_t;

endpackage

// File: rtl/nios_mul_sequencer.sv
// Issue/collect stage around the 16x16 multiplier cell: splits one 32x32
// multiply into two passes over the halves of src2, captures both partial
// products and returns the low 32 bits of the product with its tag.
module nios_mul_sequencer
    import nios_mul_pkg::*;
#(
    parameter int unsigned CELL_LATENCY = 1,
    parameter int unsigned TAG_W        = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_src1,
    input  logic [31:0]        req_src2,
    input  logic [TAG_W-1:0]   req_tag,
    output logic [31:0]        A_mul_src1,
    output logic [31:0]        A_mul_src2,
    input  logic [31:0]        A_mul_cell_result,
    output logic               mul_cell_reset_n,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_result,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               busy
);

    localparam logic [2:0] LAT3 = 3'(CELL_LATENCY);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic [MUL_W-1:0]   src1_q;
    logic [MUL_W-1:0]   src2_q;
    logic [TAG_W-1:0]   tag_q;
    logic [MUL_W-1:0]   p0_q;
    logic [MUL_W-1:0]   result_q;
    logic [2:0]         drain_cnt;
    pass_t              pass_in;
    pass_t              pass_out;
    pass_t              pass_pipe [CELL_LATENCY];

    assign mul_cell_reset_n = ~reset;
    assign pass_out         = pass_pipe[CELL_LATENCY-1];
    assign rsp_result       = result_q;
    assign rsp_tag          = tag_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, handshake outputs and cell operand steering.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        A_mul_src1 = '0;
        A_mul_src2 = '0;
        pass_in    = PASS_NONE;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = ISSUE_LO;
                end
            end
            ISSUE_LO: begin
                A_mul_src1 = src1_q;
                A_mul_src2 = {{HALF_W{1'b0}}, src2_q[HALF_W-1:0]};
                pass_in    = PASS_LO;
                state_next = ISSUE_HI;
            end
            ISSUE_HI: begin
                A_mul_src1 = src1_q;
                A_mul_src2 = {{HALF_W{1'b0}}, src2_q[MUL_W-1:HALF_W]};
                pass_in    = PASS_HI;
                state_next = DRAIN;
            end
            DRAIN: begin
                // Counter reaches 1 in the same cycle the hi-pass marker
                // emerges from the delay line, i.e. the P1 capture cycle.
                if (drain_cnt == 3'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request operand and tag capture on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            src1_q <= '0;
            src2_q <= '0;
            tag_q  <= '0;
        end else if (accept) begin
            src1_q <= req_src1;
            src2_q <= req_src2;
            tag_q  <= req_tag;
        end
    end

    // Drain down-counter, loaded as the hi pass issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if (state == ISSUE_HI) begin
            drain_cnt <= LAT3;
        end else if (state == DRAIN && drain_cnt != 3'd0) begin
            drain_cnt <= drain_cnt - 3'd1;
        end
    end

    // Pass marker delay line, aligned with the cell's result latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < CELL_LATENCY; i++) begin
                pass_pipe[i] <= PASS_NONE;
            end
        end else begin
            pass_pipe[0] <= pass_in;
            for (int unsigned i = 1; i < CELL_LATENCY; i++) begin
                pass_pipe[i] <= pass_pipe[i-1];
            end
        end
    end

    // Partial product capture and combine; the hi product is used live
    // in its capture cycle, so only P0 needs holding.
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_q     <= '0;
            result_q <= '0;
        end else begin
            if (pass_out == PASS_LO) begin
                p0_q <= A_mul_cell_result;
            end
            if (pass_out == PASS_HI) begin
                result_q <= p0_q + {A_mul_cell_result[HALF_W-1:0], {HALF_W{1'b0}}};
            end
        end
    end

endmodule

// File: tb/tb_nios_mul_sequencer.sv
// Directed bench: two sequencers (cell latency 1 and 2) driven by the same
// request stream, each paired with a behavioural multiplier cell.
module tb_nios_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic [4:0]  req_tag;
    logic        rsp_ready;

    logic        req_ready_a, req_ready_b;
    logic [31:0] mul_src1_a, mul_src1_b, mul_src2_a, mul_src2_b;
    logic [31:0] cell_a, cell_b1, cell_b2;
    logic        cell_rst_n_a, cell_rst_n_b;
    logic        rsp_valid_a, rsp_valid_b;
    logic [31:0] rsp_result_a, rsp_result_b;
    logic [4:0]  rsp_tag_a, rsp_tag_b;
    logic        busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios_mul_sequencer #(.CELL_LATENCY(1), .TAG_W(5)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_a),
        .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
        .A_mul_src1(mul_src1_a), .A_mul_src2(mul_src2_a),
        .A_mul_cell_result(cell_a), .mul_cell_reset_n(cell_rst_n_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result_a), .rsp_tag(rsp_tag_a), .busy(busy_a)
    );

    nios_mul_sequencer #(.CELL_LATENCY(2), .TAG_W(5)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_b),
        .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
        .A_mul_src1(mul_src1_b), .A_mul_src2(mul_src2_b),
        .A_mul_cell_result(cell_b2), .mul_cell_reset_n(cell_rst_n_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result_b), .rsp_tag(rsp_tag_b), .busy(busy_b)
    );

    // Behavioural cells: src1 * src2[15:0], one and two register stages.
    always @(posedge clk) begin
        if (!cell_rst_n_a) cell_a <= '0;
        else               cell_a <= mul_src1_a * {16'h0, mul_src2_a[15:0]};
    end

    always @(posedge clk) begin
        if (!cell_rst_n_b) begin
            cell_b1 <= '0;
            cell_b2 <= '0;
        end else begin
            cell_b1 <= mul_src1_b * {16'h0, mul_src2_b[15:0]};
            cell_b2 <= cell_b1;
        end
    end

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Called one sample after the accept edge (cycle 1) with rsp_ready high.
    task automatic collect(input string nm, input logic [31:0] exp, input logic [4:0] tag);
        int          lat_a = -1;
        int          lat_b = -1;
        logic [31:0] res_a = '0, res_b = '0;
        logic [4:0]  tg_a = '0, tg_b = '0;
        logic        rdy_a = 1'b0, rdy_b = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (lat_a >= 0 && k == lat_a + 1) rdy_a = req_ready_a;
            if (lat_b >= 0 && k == lat_b + 1) begin
                rdy_b = req_ready_b;
                break;
            end
            if (rsp_valid_a && lat_a < 0) begin
                lat_a = k; res_a = rsp_result_a; tg_a = rsp_tag_a;
            end
            if (rsp_valid_b && lat_b < 0) begin
                lat_b = k; res_b = rsp_result_b; tg_b = rsp_tag_b;
            end
            step();
        end
        check({nm, " lat1 latency"}, 32'(lat_a), 32'd4);
        check({nm, " lat1 result"}, res_a, exp);
        check({nm, " lat1 tag"}, {27'h0, tg_a}, {27'h0, tag});
        check({nm, " lat1 ready after"}, {31'h0, rdy_a}, 32'd1);
        check({nm, " lat2 latency"}, 32'(lat_b), 32'd5);
        check({nm, " lat2 result"}, res_b, exp);
        check({nm, " lat2 tag"}, {27'h0, tg_b}, {27'h0, tag});
        check({nm, " lat2 ready after"}, {31'h0, rdy_b}, 32'd1);
    endtask

    // Presents a request in an idle cycle and returns one sample after accept.
    task automatic issue(input string nm, input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] tag);
        req_src1  = s1;
        req_src2  = s2;
        req_tag   = tag;
        req_valid = 1'b1;
        check({nm, " ready lat1"}, {31'h0, req_ready_a}, 32'd1);
        check({nm, " ready lat2"}, {31'h0, req_ready_b}, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;

        vecs[0] = '{32'h0000_0003, 32'h0000_0005, 5'd7,  32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
        vecs[2] = '{32'h0001_2345, 32'h0001_0000, 5'd1,  32'h2345_0000};
        vecs[3] = '{32'h0001_0000, 32'h0001_0000, 5'd2,  32'h0000_0000};
        vecs[4] = '{32'h0000_FFFF, 32'h0000_FFFF, 5'd3,  32'hFFFE_0001};
        vecs[5] = '{32'h0001_0000, 32'h0001_0001, 5'd4,  32'h0001_0000};
        vecs[6] = '{32'hDEAD_BEEF, 32'h0000_0002, 5'd5,  32'hBD5B_7DDE};
        vecs[7] = '{32'h0000_0002, 32'h8000_0000, 5'd6,  32'h0000_0000};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_src1  = '0;
        req_src2  = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        repeat (3) step();
        check("cell reset_n low in reset", {31'h0, cell_rst_n_a}, 32'd0);
        reset = 1'b0;
        step();
        check("reset req_ready", {31'h0, req_ready_a}, 32'd1);
        check("reset rsp_valid", {31'h0, rsp_valid_a}, 32'd0);
        check("reset rsp_result", rsp_result_a, 32'd0);
        check("reset rsp_tag", {27'h0, rsp_tag_a}, 32'd0);
        check("reset src1", mul_src1_a, 32'd0);
        check("reset src2", mul_src2_a, 32'd0);
        check("reset busy", {31'h0, busy_a}, 32'd0);
        check("reset busy lat2", {31'h0, busy_b}, 32'd0);
        check("cell reset_n high", {31'h0, cell_rst_n_a}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].s1, vecs[i].s2, vecs[i].tag);
            collect($sformatf("vec%0d", i), vecs[i].exp, vecs[i].tag);
        end

        // Backpressure: hold rsp_ready low while a new request waits.
        rsp_ready = 1'b0;
        issue("bp", 32'h0000_1234, 32'h0002_0003, 5'd9);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (rsp_valid_b) seen = 1'b1;
            else step();
        end
        check("bp response seen", {31'h0, seen}, 32'd1);
        req_src1  = 32'hDEAD_BEEF;
        req_src2  = 32'h0000_0002;
        req_tag   = 5'd12;
        req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("bp valid lat1", {31'h0, rsp_valid_a}, 32'd1);
            check("bp valid lat2", {31'h0, rsp_valid_b}, 32'd1);
            check("bp result lat1", rsp_result_a, 32'h2468_369C);
            check("bp result lat2", rsp_result_b, 32'h2468_369C);
            check("bp tag lat1", {27'h0, rsp_tag_a}, 32'd9);
            check("bp tag lat2", {27'h0, rsp_tag_b}, 32'd9);
            check("bp req_ready lat1", {31'h0, req_ready_a}, 32'd0);
            check("bp req_ready lat2", {31'h0, req_ready_b}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("bp release valid lat1", {31'h0, rsp_valid_a}, 32'd0);
        check("bp release valid lat2", {31'h0, rsp_valid_b}, 32'd0);
        check("bp release ready lat1", {31'h0, req_ready_a}, 32'd1);
        check("bp release ready lat2", {31'h0, req_ready_b}, 32'd1);
        step();
        req_valid = 1'b0;
        check("bp next accepted lat1", {31'h0, busy_a}, 32'd1);
        check("bp next accepted lat2", {31'h0, busy_b}, 32'd1);
        collect("bp next", 32'hBD5B_7DDE, 5'd12);

        // Reset pulsed in the ISSUE_HI cycle.
        issue("rst", 32'hFFFF_FFFF, 32'h0005_0003, 5'd11);
        step();
        check("rst hi operand lat1", mul_src2_a, 32'h0000_0005);
        check("rst hi operand lat2", mul_src2_b, 32'h0000_0005);
        reset = 1'b1;
        #1;
        check("rst cell reset_n", {31'h0, cell_rst_n_a}, 32'd0);
        step();
        reset = 1'b0;
        check("rst idle lat1", {31'h0, busy_a}, 32'd0);
        check("rst idle lat2", {31'h0, busy_b}, 32'd0);
        check("rst ready lat1", {31'h0, req_ready_a}, 32'd1);
        check("rst operand cleared", mul_src1_a, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seen = seen | rsp_valid_a | rsp_valid_b;
            step();
        end
        check("rst no response", {31'h0, seen}, 32'd0);
        issue("after rst", 32'h0000_0007, 32'h0000_0006, 5'd3);
        collect("after rst", 32'h0000_002A, 5'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_mul_sequencer.md
Name: nios_mul_sequencer

Overview:
- Issue and collect stage directly upstream and downstream of the 16x16 multiplier cell in the Nios II execute path.
- Accepts one 32x32 multiply request and drives the cell for two passes: low half of src2, then high half of src2.
- Captures both partial products and combines them into the low 32 bits of the product.
- Returns the result with the request's destination tag over a valid/ready handshake.

Parameters:
- CELL_LATENCY, 1: cycles from operands on A_mul_src1/2 to matching A_mul_cell_result; legal 1..4.
- TAG_W, 5: width of the request/response tag (destination register index).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_src1  in  32  multiplicand.
- req_src2  in  32  multiplier.
- req_tag  in  TAG_W  destination tag.
- A_mul_src1  out  32  cell operand 1.
- A_mul_src2  out  32  cell operand 2; only [15:0] is consumed by the cell.
- A_mul_cell_result  in  32  cell result = src1 * src2[15:0], mod 2^32, for the low pass.
- mul_cell_reset_n  out  1  cell clear, = ~reset, combinational.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  32  low 32 bits of req_src1*req_src2.
- rsp_tag  out  TAG_W  tag of the request.
- busy  out  1  state != IDLE.

Behaviour:
- One clock, clk. Reset is synchronous and active-high; all state lives in the clk domain.
- Reset values: state IDLE; req_ready 1 (combinational from IDLE); rsp_valid 0; rsp_result 0; rsp_tag 0; A_mul_src1/2 0; busy 0.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, register src1, src2 and tag, then go to ISSUE_LO.
  - ISSUE_LO (1 cycle): A_mul_src1=src1, A_mul_src2={16'h0,src2[15:0]}. Go to ISSUE_HI.
  - ISSUE_HI (1 cycle): A_mul_src1=src1, A_mul_src2={16'h0,src2[31:16]}. Go to DRAIN.
  - DRAIN: down-counter loaded with CELL_LATENCY. Go to RESP when the hi-pass result has been captured.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- A_mul_src1/2 are 0 in every state other than ISSUE_LO and ISSUE_HI.
- Capture timing: a 2-bit pass marker delay line of depth CELL_LATENCY.
  - Low result P0 is captured in cycle (ISSUE_LO cycle + CELL_LATENCY).
  - High result P1 is captured in cycle (ISSUE_HI cycle + CELL_LATENCY).
- Combine, registered on P1 capture: rsp_result = P0 + {P1[15:0],16'h0}, mod 2^32.
- Signed and unsigned operands give identical low words; there is no sign handling. Overflow wraps silently.
- Latency: accept at cycle 0 gives rsp_valid at cycle CELL_LATENCY+3.
- Throughput: one request per CELL_LATENCY+4 cycles at best. req_ready is 0 outside IDLE; no request overlap.
- Backpressure: in RESP, rsp_result and rsp_tag stay stable and rsp_valid stays 1 until rsp_ready. req_ready stays 0 meanwhile.
- A rsp handshake and a new request never occur in the same cycle; the new request is accepted at earliest in the following IDLE cycle.
- Reset mid-operation, in any state: the next cycle is IDLE with rsp_valid 0. The in-flight request is discarded and no response is emitted. mul_cell_reset_n is low for the whole reset so the cell's internal registers clear.
- Cell outputs are ignored except in the marked capture cycles.

Decomposition:
- Package nios_mul_pkg holds:
  - state enum (IDLE, ISSUE_LO, ISSUE_HI, DRAIN, RESP);
  - MUL_W=32, HALF_W=16;
  - pass marker encoding (NONE, LO, HI).
- No sub-module; the marker delay line and the combine adder stay inline.
- The bench instantiates the real cell, or a behavioural cell model with parameterised latency.

Test Plan:
- req 3 x 5, tag 7, rsp_ready=1, CELL_LATENCY=1 -> rsp_valid in cycle 4 after accept, rsp_result 0x0000000F, rsp_tag 7, req_ready back to 1 in cycle 5.
- req 0xFFFFFFFF x 0xFFFFFFFF -> rsp_result 0x00000001; P0 and P1 paths both exercised.
- req 0x00012345 x 0x00010000 -> low pass 0, high pass 0x2345, rsp_result 0x23450000.
- rsp_ready held 0 for 10 cycles after rsp_valid -> result and tag stable, req_ready 0 with req_valid asserted. On release, the handshake completes and the next request is accepted the following cycle.
- reset pulsed in the ISSUE_HI cycle -> next cycle IDLE, rsp_valid never asserted for that request. A following 7 x 6 returns 0x0000002A.
- CELL_LATENCY=2 with model cell: 0x00010000 x 0x00010000 -> rsp_result 0x00000000 at cycle 5 after accept; 0x0000FFFF x 0x0000FFFF -> 0xFFFE0001.
